// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner.
//   btn_state_e  : per-channel debounce FSM state
//   btn_evt_t    : per-channel conditioned outputs (level + event pulses)
//   DEF_*        : default timing constants for a 100 MHz system clock
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;    // 10 ms
    localparam int DEF_LONG_PRESS_CYCLES = 100_000_000;  // 1 s

    typedef struct packed {
        logic level;  // debounced pressed level
        logic press;  // accepted press pulse
        logic rel;    // accepted release pulse
        logic lng;    // long-press pulse
    } btn_evt_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: 2-flop synchronizer, 4-state debounce FSM,
// debounce and long-press counters, registered level and pulse outputs.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : asynchronous raw button pin
//   evt   : registered level / press / release / long-press outputs
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int   LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter logic ACTIVE_LOW        = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     raw,
    output btn_evt_t evt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_PRESS_CYCLES);

    logic [1:0]    sync_q;
    logic          sync;
    btn_state_e    state;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] long_cnt;

    // Polarity fix-up happens before the first flop so everything
    // downstream sees 1 = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], raw ^ ACTIVE_LOW};
    end

    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RELEASED;
            deb_cnt  <= '0;
            long_cnt <= '0;
            evt      <= '0;
        end else begin
            evt.press <= 1'b0;
            evt.rel   <= 1'b0;
            evt.lng   <= 1'b0;

            // Hold timer runs through DEB_RELEASE too, so a short release
            // glitch does not shift the long-press pulse. Saturation makes
            // the pulse fire once per press.
            if (evt.level && long_cnt != LONG_MAX) begin
                long_cnt <= long_cnt + LW'(1);
                if (long_cnt == LONG_MAX - LW'(1)) evt.lng <= 1'b1;
            end

            case (state)
                RELEASED: begin
                    if (sync) begin
                        state   <= DEB_PRESS;
                        deb_cnt <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!sync) begin
                        state <= RELEASED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= PRESSED;
                        evt.level <= 1'b1;
                        evt.press <= 1'b1;
                        long_cnt  <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state   <= DEB_RELEASE;
                        deb_cnt <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (sync) begin
                        state <= PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= RELEASED;
                        evt.level <= 1'b0;
                        evt.rel   <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner between board pins and core logic.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   btn_raw     : asynchronous raw buttons
//   btn_level   : debounced pressed level per channel
//   btn_press   : one-cycle pulse per accepted press
//   btn_release : one-cycle pulse per accepted release
//   btn_long    : one-cycle pulse once per press after the long-press hold
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int   NUM_BTN           = 2,
    parameter int   DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int   LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter logic ACTIVE_LOW        = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_evt_t evt;

        btn_debounce_ch #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .evt  (evt)
        );

        assign btn_level[i]   = evt.level;
        assign btn_press[i]   = evt.press;
        assign btn_release[i] = evt.rel;
        assign btn_long[i]    = evt.lng;
    end

endmodule
